bw_frame_ctrl: RTL and testbench



---
 rtl/bw_pkg.sv | 26 ++
 rtl/bw_frame_ctrl_if.sv | 33 +++
 rtl/bw_addr_gen.sv | 49 ++++
 rtl/bw_frame_ctrl.sv | 127 ++++++++++++
 tb/tb_bw_frame_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bw_pkg.sv
// Shared types and defaults for the grayscale-to-B/W frame controller.
// Optional inverted-polarity output is enabled by the BW_INVERT_EN macro.
package bw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LAT,
        OUT,
        DONE
    } bw_state_t;

    localparam int BW_PIX_W  = 8;
    localparam int BW_IMG_W  = 128;
    localparam int BW_IMG_H  = 128;
    localparam int BW_ADDR_W = 14;

    localparam logic [BW_PIX_W-1:0] BW_WHITE = 8'hFF;
    localparam logic [BW_PIX_W-1:0] BW_BLACK = 8'h00;

    // Counter width that stays at least one bit for a dimension of size 1.
    function automatic int bw_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bw_frame_ctrl_if.sv
// Pixel-memory read port plus the thresholded pixel stream, as seen by bw_frame_ctrl.
interface bw_frame_ctrl_if
    import bw_pkg::*;
#(
    parameter int PIX_W  = BW_PIX_W,
    parameter int ADDR_W = BW_ADDR_W
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [PIX_W-1:0]  mem_rdata;

    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_eol;
    logic              pix_last;

    modport master (
        output mem_addr, mem_re,
        input  mem_rdata,
        output pix_valid, pix_data, pix_eol, pix_last,
        input  pix_ready
    );

    modport slave (
        input  mem_addr, mem_re,
        output mem_rdata,
        input  pix_valid, pix_data, pix_eol, pix_last,
        output pix_ready
    );

endinterface

// File: rtl/bw_addr_gen.sv
// Raster-order row/col counters producing the linear pixel address and line/frame flags.
module bw_addr_gen
    import bw_pkg::*;
#(
    parameter int IMG_W  = BW_IMG_W,
    parameter int IMG_H  = BW_IMG_H,
    parameter int ADDR_W = BW_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              eol_o,
    output logic              last_o
);

    localparam int COL_W = bw_cnt_w(IMG_W);
    localparam int ROW_W = bw_cnt_w(IMG_H);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] addr_q;

    // In raster order row*IMG_W+col simply counts up, so a running address avoids a multiplier.
    // NOTE: reset is sampled on the clock edge here, so it shares the same path as clr_i.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else if (adv_i) begin
            addr_q <= addr_q + 1'b1;
            if (eol_o) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign addr_o = addr_q;
    assign eol_o  = (col_q == COL_MAX);
    assign last_o = eol_o && (row_q == ROW_MAX);

endmodule

// File: rtl/bw_frame_ctrl.sv
// Frame controller: reads a whole frame in raster order, thresholds each pixel, streams it out.
// Define BW_INVERT_EN to add invert_i, which flips the output polarity for a frame.
module bw_frame_ctrl
    import bw_pkg::*;
#(
    parameter int IMG_W  = BW_IMG_W,
    parameter int IMG_H  = BW_IMG_H,
    parameter int PIX_W  = BW_PIX_W,
    parameter int ADDR_W = BW_ADDR_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [PIX_W-1:0] threshold_i,
`ifdef BW_INVERT_EN
    input  logic             invert_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    bw_frame_ctrl_if.master  bus
);

    bw_state_t         state_q, state_d;
    logic [PIX_W-1:0]  thr_q;
    logic              inv_q;
    logic              load, adv, hs, abort_act;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_eol, gen_last;
    logic              pix_valid_q, pix_eol_q, pix_last_q;
    logic [PIX_W-1:0]  pix_data_q;

    bw_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (load),
        .adv_i  (adv),
        .addr_o (gen_addr),
        .eol_o  (gen_eol),
        .last_o (gen_last)
    );

    assign hs        = pix_valid_q && bus.pix_ready;
    assign abort_act = abort_i && (state_q != IDLE);

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: if (start_i) begin
                load    = 1'b1;
                state_d = RD;
            end
            RD:   state_d = LAT;
            LAT:  state_d = OUT;
            OUT:  if (hs) begin
                if (gen_last) begin
                    state_d = DONE;
                end else begin
                    adv     = 1'b1;
                    state_d = RD;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort outranks the handshake and freezes the counters where they are.
        if (abort_act) begin
            state_d = IDLE;
            adv     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            thr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) thr_q <= threshold_i;
        end
    end

`ifdef BW_INVERT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni)   inv_q <= 1'b0;
        else if (load) inv_q <= invert_i;
    end
`else
    assign inv_q = 1'b0;
`endif

    // Memory data is registered in the RAM, so it is present during LAT and sampled at its end.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || abort_act) begin
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_eol_q   <= 1'b0;
            pix_last_q  <= 1'b0;
        end else if (state_q == LAT) begin
            pix_valid_q <= 1'b1;
            pix_data_q  <= ((bus.mem_rdata >= thr_q) ^ inv_q) ? {PIX_W{1'b1}} : '0;
            pix_eol_q   <= gen_eol;
            pix_last_q  <= gen_last;
        end else if (hs) begin
            pix_valid_q <= 1'b0;
            pix_eol_q   <= 1'b0;
            pix_last_q  <= 1'b0;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign bus.mem_re    = (state_q == RD);
    assign bus.mem_addr  = (state_q == RD) ? gen_addr : '0;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_data  = pix_data_q;
    assign bus.pix_eol   = pix_eol_q;
    assign bus.pix_last  = pix_last_q;

endmodule

// File: tb/tb_bw_frame_ctrl.sv
// Self-checking bench for bw_frame_ctrl on a 4x2 frame: directed scenarios plus random frames.
module tb_bw_frame_ctrl;
    import bw_pkg::*;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;
    localparam int AW   = 3;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       start_i, abort_i;
    logic [7:0] threshold_i;
    logic       tb_inv;
    logic       busy_o, done_o;

    bw_frame_ctrl_if #(.PIX_W(8), .ADDR_W(AW)) bus ();

    bw_frame_ctrl #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (8),
        .ADDR_W(AW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .threshold_i (threshold_i),
`ifdef BW_INVERT_EN
        .invert_i    (tb_inv),
`endif
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bus         (bus.master)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous pixel memory: data valid one cycle after the read strobe.
    logic [7:0] mem [NPIX];
    always @(posedge clk_i) if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];

    int         n_vec = 0, n_err = 0;
    int         rd_cnt = 0, rd_base = 0, px_cnt = 0, px_base = 0;
    int         done_cnt = 0, ff_cnt = 0;
    logic [7:0] exp_thr;
    logic       exp_inv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: pixel i of the frame is white when mem[i] >= threshold, flipped by invert.
    function automatic logic [7:0] exp_pix(input int i);
        logic white;
        white = (mem[i] >= exp_thr);
        if (exp_inv) white = !white;
        return white ? BW_WHITE : BW_BLACK;
    endfunction

    // One clock: observe at the falling edge, then return just after the rising edge.
    task automatic tick();
        int i;
        @(negedge clk_i);
        if (bus.mem_re === 1'b1) begin
            check("rd_addr", 32'(bus.mem_addr), rd_cnt - rd_base);
            rd_cnt++;
        end
        if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) begin
            i = px_cnt - px_base;
            check("pix_in_frame", 32'(i < NPIX), 1);
            if (i < NPIX) begin
                check("pix_data", bus.pix_data, exp_pix(i));
                check("pix_eol", bus.pix_eol, (i % W) == W - 1);
                check("pix_last", bus.pix_last, i == NPIX - 1);
            end
            if (bus.pix_data == BW_WHITE) ff_cnt++;
            px_cnt++;
        end
        if (done_o === 1'b1) begin
            done_cnt++;
            check("done_after_last", px_cnt - px_base, NPIX);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] thr, input logic inv, input logic with_abort);
        threshold_i = thr;
        tb_inv      = inv;
        start_i     = 1'b1;
        abort_i     = with_abort;
        exp_thr     = thr;
`ifdef BW_INVERT_EN
        exp_inv     = inv;
`else
        exp_inv     = 1'b0;
`endif
        px_base = px_cnt;
        rd_base = rd_cnt;
        ff_cnt  = 0;
        tick();
        start_i     = 1'b0;
        abort_i     = 1'b0;
        threshold_i = 8'($urandom);
        tb_inv      = 1'($urandom);
        check("first_re", bus.mem_re, 1'b1);
    endtask

    task automatic run_until_done(input int max_cyc, input bit rnd_ready, output int cyc);
        cyc = 0;
        while (done_o !== 1'b1 && cyc < max_cyc) begin
            if (rnd_ready) bus.pix_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        bus.pix_ready = 1'b1;
        check("done_seen", done_o, 1'b1);
    endtask

    task automatic finish_frame(input int done_before);
        tick();
        check("done_width", done_o, 1'b0);
        check("idle_after_done", busy_o, 1'b0);
        check("pix_count", px_cnt - px_base, NPIX);
        check("done_count", done_cnt - done_before, 1);
    endtask

    task automatic wait_pixel(input int idx);
        int n = 0;
        while (!(bus.pix_valid === 1'b1 && px_cnt - px_base == idx) && n < 50) begin
            tick();
            n++;
        end
        check("reach_pixel", px_cnt - px_base, idx);
    endtask

    task automatic load_s1();
        logic [7:0] s1 [NPIX];
        s1 = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h10, 8'h90, 8'h80, 8'h01};
        for (int i = 0; i < NPIX; i++) mem[i] = s1[i];
    endtask

    initial begin
        int         cyc, db, n;
        logic [7:0] snap_d;
        logic       snap_e, snap_l;

        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; threshold_i = 8'h00; tb_inv = 1'b0;
        bus.pix_ready = 1'b1;
        exp_thr = 8'h00; exp_inv = 1'b0;
        load_s1();
        tick(); tick();
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_re", bus.mem_re, 0);
        check("rst_addr", 32'(bus.mem_addr), 0);
        check("rst_valid", bus.pix_valid, 0);
        check("rst_data", bus.pix_data, 0);
        check("rst_eol", bus.pix_eol, 0);
        check("rst_last", bus.pix_last, 0);
        rst_ni = 1'b1;
        tick();

        // Basic frame; start and a new threshold are poked mid-frame and must be ignored.
        db = done_cnt;
        start_frame(8'h80, 1'b0, 1'b0);
        start_i = 1'b1; threshold_i = 8'h00;
        for (int k = 0; k < 4; k++) tick();
        start_i = 1'b0;
        run_until_done(100, 1'b0, cyc);
        check("frame_cycles", 4 + cyc, 3 * NPIX);
        finish_frame(db);
        check("white_count_s1", ff_cnt, 4);

        // Backpressure on pixel 1.
        db = done_cnt;
        start_frame(8'h80, 1'b0, 1'b0);
        wait_pixel(1);
        bus.pix_ready = 1'b0;
        snap_d = bus.pix_data; snap_e = bus.pix_eol; snap_l = bus.pix_last;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_valid", bus.pix_valid, 1);
            check("stall_data", bus.pix_data, snap_d);
            check("stall_flags", {bus.pix_eol, bus.pix_last}, {snap_e, snap_l});
            check("stall_no_re", bus.mem_re, 0);
        end
        bus.pix_ready = 1'b1;
        run_until_done(100, 1'b0, cyc);
        finish_frame(db);

        // Reset during OUT of pixel 4, then a clean frame from address 0.
        start_frame(8'h80, 1'b0, 1'b0);
        wait_pixel(4);
        rst_ni = 1'b0; bus.pix_ready = 1'b0;
        tick();
        check("mrst_busy", busy_o, 0);
        check("mrst_valid", bus.pix_valid, 0);
        check("mrst_outs", {bus.pix_data, bus.pix_eol, bus.pix_last, bus.mem_re, done_o}, 0);
        check("mrst_addr", 32'(bus.mem_addr), 0);
        rst_ni = 1'b1; bus.pix_ready = 1'b1;
        tick();
        db = done_cnt;
        start_frame(8'h80, 1'b0, 1'b0);
        run_until_done(100, 1'b0, cyc);
        finish_frame(db);

        // Abort (with a competing start) in LAT of pixel 2.
        db = done_cnt;
        start_frame(8'h80, 1'b0, 1'b0);
        n = 0;
        while (!(bus.mem_re === 1'b1 && bus.mem_addr == 3'd2) && n < 50) begin
            tick();
            n++;
        end
        tick();
        abort_i = 1'b1; start_i = 1'b1;
        tick();
        abort_i = 1'b0; start_i = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_valid", bus.pix_valid, 0);
        for (int k = 0; k < 3; k++) tick();
        check("abort_idle", busy_o, 0);
        check("abort_no_done", done_cnt - db, 0);
        check("abort_pix", px_cnt - px_base, 2);
        check("abort_reads", rd_cnt - rd_base, 3);

        // Start together with abort in IDLE is accepted; threshold 0 makes every pixel white.
        db = done_cnt;
        start_frame(8'h00, 1'b0, 1'b1);
        check("start_over_abort", busy_o, 1);
        run_until_done(100, 1'b0, cyc);
        finish_frame(db);
        check("white_count_thr0", ff_cnt, NPIX);

`ifdef BW_INVERT_EN
        db = done_cnt;
        start_frame(8'h80, 1'b1, 1'b0);
        run_until_done(100, 1'b0, cyc);
        finish_frame(db);
        check("white_count_inv", ff_cnt, NPIX - 4);
`endif

        // Random frames with random data, thresholds and ready.
        for (int f = 0; f < 8; f++) begin
            logic [7:0] thr;
            logic       inv;
            for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
            thr = (f == 0) ? 8'hFF : 8'($urandom);
            inv = 1'($urandom);
            db = done_cnt;
            start_frame(thr, inv, 1'b0);
            run_until_done(400, 1'b1, cyc);
            finish_frame(db);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
